wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter MS_TO_WS_BUS_WD, default 102, width of the mem-to-wb bus.
REQ-002 Parameter WS_TO_RF_BUS_WD, default 38, width of the regfile/forwarding bus.
REQ-003 Parameter TRACE_DEPTH, default 4, commit-trace FIFO entries (power of 2, >=2).
REQ-004 One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  pipeline flush.
REQ-006 stall  in  6  pipeline stall vector; bit 4 = WB stage, bit 5 = beyond WB.
REQ-007 ms_to_ws_bus  in  102  {reg_we[101], dest[100:96], result[95:64], pc[63:32], inst[31:0]}.
REQ-008 ws_to_rf_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}, regfile write port.
REQ-009 ws_to_ds_bus  out  38  {we, dest, result}, forwarding to decode.
REQ-010 stallreq_ws  out  1  WB cannot commit this cycle.
REQ-011 debug_wb_valid  out  1  trace FIFO head valid.
REQ-012 debug_wb_ready  in  1  trace consumer accepts head.
REQ-013 debug_wb_pc  out  32; debug_wb_rf_we  out  4; debug_wb_rf_wnum  out  5; debug_wb_rf_wdata  out  32; all describe FIFO head.

Function
REQ-014 WB register shall load ms_to_ws_bus on a clk edge when stall[4]=0 and no flush is applied.
REQ-015 When stall[4]=1 and stall[5]=0, WB register shall load all-zero (bubble).
REQ-016 When stall[4]=1 and stall[5]=1, WB register shall hold.
REQ-017 Flush shall load all-zero unless stallreq_ws=1, in which case the WB register and pending flag hold (older instruction must retire).
REQ-018 Priority per edge: flush > stall[4]&!stall[5] bubble > !stall[4] load > hold.
REQ-019 A WB entry with pc field != 0 is a valid instruction; pc = 0 is a bubble.
REQ-020 Pending flag: set when a valid instruction is loaded; cleared on the edge it commits; cleared on bubble load.
REQ-021 Commit condition (combinational): pending & (fifo not full | pop this cycle).
REQ-022 Commit shall push {pc, reg_we, dest, result} into the trace FIFO and, in the same cycle, drive rf_we = reg_we; rf_we = 0 otherwise.
REQ-023 Each instruction shall write the regfile and push the FIFO exactly once, regardless of hold duration.
REQ-024 rf_waddr/rf_wdata shall equal dest/result of the WB register whenever rf_we=1.
REQ-025 ws_to_ds_bus shall present {reg_we & valid, dest, result} whenever the WB register is valid, independent of commit.
REQ-026 stallreq_ws = pending & full & !pop, combinational.
REQ-027 Pop occurs when debug_wb_valid & debug_wb_ready; debug_wb_valid = (count != 0).
REQ-028 Simultaneous push and pop on a full FIFO: both occur, count unchanged.
REQ-029 Simultaneous push and pop on an empty FIFO: entry pushed, no pop (head invalid), count becomes 1.
REQ-030 Read/write pointers shall wrap modulo TRACE_DEPTH; count range 0..TRACE_DEPTH.
REQ-031 debug_wb_rf_we = {4{head.reg_we}}; debug outputs are 0 when FIFO empty.
REQ-032 Flush shall not alter FIFO contents.
REQ-033 Latency: instruction loaded at edge N commits in cycle N (same cycle) if FIFO not full; appears on debug outputs from edge N+1.

Reset
REQ-034 resetn=0 shall asynchronously clear WB register, pending flag, pointers and count; all outputs 0 while asserted and until the first load.
REQ-035 Reset mid-hold shall discard the uncommitted instruction without a regfile write.

Verification
REQ-036 Load pc=0x1C000000, reg_we=1, dest=5, result=0xDEADBEEF, ready=1 -> rf_we=1 one cycle, waddr 5; next cycle debug_wb_pc=0x1C000000, rf_we=4'hF.
REQ-037 ready=0, four valid instructions -> FIFO full; fifth -> stallreq_ws=1, rf_we=0; raise ready one cycle -> fifth commits same cycle, stallreq_ws=0.
REQ-038 stall[4]=1, stall[5]=1 for 3 cycles on a committed instruction -> exactly one rf write, one FIFO push.
REQ-039 flush while stallreq_ws=1 -> WB instruction held, commits after pop; flush while stallreq_ws=0 -> WB becomes bubble, no write.
REQ-040 resetn low mid-operation with 3 FIFO entries -> debug_wb_valid=0 immediately, ws_to_rf_bus=0.
REQ-041 Bubble input (all-zero bus) -> no push, rf_we=0, ws_to_ds_bus.we=0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: WB pipeline register, single-shot regfile commit and a
// commit-trace FIFO that can back-pressure the pipeline when its consumer stalls.
module wb_stage #(
    parameter int MS_TO_WS_BUS_WD = 102,
    parameter int WS_TO_RF_BUS_WD = 38,
    parameter int TRACE_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic [5:0]                 stall,
    input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
    output logic [WS_TO_RF_BUS_WD-1:0] ws_to_ds_bus,
    output logic                       stallreq_ws,
    output logic                       debug_wb_valid,
    input  logic                       debug_wb_ready,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(TRACE_DEPTH);

    logic [MS_TO_WS_BUS_WD-1:0] wb_reg_r;
    logic [MS_TO_WS_BUS_WD-1:0] wb_next_s;
    logic                       pending_r;
    logic                       pending_next_s;

    logic [69:0]      trace_mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic        wb_we_s;
    logic [4:0]  wb_dest_s;
    logic [31:0] wb_result_s;
    logic [31:0] wb_pc_s;
    logic        wb_valid_s;
    logic        full_s;
    logic        pop_s;
    logic        push_s;
    logic        commit_s;
    logic [69:0] head_s;
    logic [37:0] rf_bus_s;
    logic [37:0] ds_bus_s;
    logic        unused_s;

    assign wb_we_s     = wb_reg_r[101];
    assign wb_dest_s   = wb_reg_r[100:96];
    assign wb_result_s = wb_reg_r[95:64];
    assign wb_pc_s     = wb_reg_r[63:32];
    assign wb_valid_s  = (wb_pc_s != 32'h0);
    assign unused_s    = ^{wb_reg_r[31:0], stall[3:0]};

    assign full_s         = (count_r == DEPTH_C);
    assign debug_wb_valid = (count_r != {(PTR_W + 1){1'b0}});
    assign pop_s          = debug_wb_valid & debug_wb_ready;
    // A pop in the same cycle frees the slot the commit needs, so it may proceed.
    assign commit_s       = pending_r & (~full_s | pop_s);
    assign push_s         = commit_s;
    assign stallreq_ws    = pending_r & full_s & ~pop_s;
    assign head_s         = trace_mem_r[rd_ptr_r];

    // Regfile write port and decode forwarding bus.
    always_comb begin
        rf_bus_s = 38'h0;
        ds_bus_s = 38'h0;
        if (commit_s && wb_we_s) begin
            rf_bus_s = {1'b1, wb_dest_s, wb_result_s};
        end else begin
            rf_bus_s = 38'h0;
        end
        if (wb_valid_s) begin
            ds_bus_s = {wb_we_s, wb_dest_s, wb_result_s};
        end else begin
            ds_bus_s = 38'h0;
        end
    end

    assign ws_to_rf_bus = WS_TO_RF_BUS_WD'(rf_bus_s);
    assign ws_to_ds_bus = WS_TO_RF_BUS_WD'(ds_bus_s);

    // Debug trace outputs describe the FIFO head and are zero while it is empty.
    always_comb begin
        debug_wb_pc       = 32'h0;
        debug_wb_rf_we    = 4'h0;
        debug_wb_rf_wnum  = 5'h0;
        debug_wb_rf_wdata = 32'h0;
        if (debug_wb_valid) begin
            debug_wb_pc       = head_s[69:38];
            debug_wb_rf_we    = {4{head_s[37]}};
            debug_wb_rf_wnum  = head_s[36:32];
            debug_wb_rf_wdata = head_s[31:0];
        end else begin
            debug_wb_pc       = 32'h0;
        end
    end

    // WB register next state: flush, then bubble, then load, then hold.
    always_comb begin
        wb_next_s      = wb_reg_r;
        pending_next_s = pending_r & ~commit_s;
        if (flush) begin
            if (stallreq_ws) begin
                wb_next_s      = wb_reg_r;
                pending_next_s = pending_r;
            end else begin
                wb_next_s      = {MS_TO_WS_BUS_WD{1'b0}};
                pending_next_s = 1'b0;
            end
        end else if (stall[4] && !stall[5]) begin
            wb_next_s      = {MS_TO_WS_BUS_WD{1'b0}};
            pending_next_s = 1'b0;
        end else if (!stall[4]) begin
            wb_next_s      = ms_to_ws_bus;
            pending_next_s = (ms_to_ws_bus[63:32] != 32'h0);
        end else begin
            wb_next_s      = wb_reg_r;
        end
    end

    // WB register and pending flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_reg_r  <= {MS_TO_WS_BUS_WD{1'b0}};
            pending_r <= 1'b0;
        end else begin
            wb_reg_r  <= wb_next_s;
            pending_r <= pending_next_s;
        end
    end

    // Trace FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            trace_mem_r[wr_ptr_r] <= {wb_pc_s, wb_we_s, wb_dest_s, wb_result_s};
        end
    end

    // Trace FIFO pointers and occupancy; pointers wrap naturally at a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for the single-step flow plus
// hand sequences for back-pressure, flush, hold and asynchronous reset.
module tb_wb_stage;

    logic         clk;
    logic         resetn;
    logic         flush;
    logic [5:0]   stall;
    logic [101:0] ms_to_ws_bus;
    logic [37:0]  ws_to_rf_bus;
    logic [37:0]  ws_to_ds_bus;
    logic         stallreq_ws;
    logic         debug_wb_valid;
    logic         debug_wb_ready;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_stage #(.MS_TO_WS_BUS_WD(102), .WS_TO_RF_BUS_WD(38), .TRACE_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
        .ms_to_ws_bus(ms_to_ws_bus), .ws_to_rf_bus(ws_to_rf_bus),
        .ws_to_ds_bus(ws_to_ds_bus), .stallreq_ws(stallreq_ws),
        .debug_wb_valid(debug_wb_valid), .debug_wb_ready(debug_wb_ready),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   stall;
        logic         flush;
        logic         ready;
        logic [101:0] bus;
        logic [37:0]  exp_rf;
        logic [37:0]  exp_ds;
        logic         exp_sreq;
        logic         exp_dv;
        logic [31:0]  exp_dpc;
        logic [3:0]   exp_dwe;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [101:0] mk(input logic we, input logic [4:0] dest,
                                        input logic [31:0] res, input logic [31:0] pc);
        return {we, dest, res, pc, 32'h0000_0013};
    endfunction

    function automatic logic [37:0] mkrf(input logic we, input logic [4:0] dest,
                                         input logic [31:0] res);
        return {we, dest, res};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] s, input logic f, input logic [101:0] b);
        stall = s;
        flush = f;
        ms_to_ws_bus = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        stall = 6'h0;
        flush = 1'b0;
        ms_to_ws_bus = 102'h0;
        debug_wb_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int writes;
        int seen;

        vecs[0] = '{6'h00, 1'b0, 1'b1, mk(1'b1, 5'd5, 32'hDEADBEEF, 32'h1C000000),
                    mkrf(1'b1, 5'd5, 32'hDEADBEEF), mkrf(1'b1, 5'd5, 32'hDEADBEEF),
                    1'b0, 1'b0, 32'h0, 4'h0};
        vecs[1] = '{6'h00, 1'b0, 1'b1, 102'h0,
                    38'h0, 38'h0, 1'b0, 1'b1, 32'h1C000000, 4'hF};
        vecs[2] = '{6'h00, 1'b0, 1'b1, mk(1'b0, 5'd7, 32'h12345678, 32'h1C000004),
                    38'h0, mkrf(1'b0, 5'd7, 32'h12345678), 1'b0, 1'b0, 32'h0, 4'h0};
        vecs[3] = '{6'h00, 1'b0, 1'b1, mk(1'b1, 5'd31, 32'hCAFEF00D, 32'h1C000008),
                    mkrf(1'b1, 5'd31, 32'hCAFEF00D), mkrf(1'b1, 5'd31, 32'hCAFEF00D),
                    1'b0, 1'b1, 32'h1C000004, 4'h0};
        vecs[4] = '{6'h10, 1'b0, 1'b1, mk(1'b1, 5'd3, 32'h0BADF00D, 32'h1C00000C),
                    38'h0, 38'h0, 1'b0, 1'b1, 32'h1C000008, 4'hF};
        vecs[5] = '{6'h00, 1'b1, 1'b1, mk(1'b1, 5'd3, 32'h0BADF00D, 32'h1C00000C),
                    38'h0, 38'h0, 1'b0, 1'b0, 32'h0, 4'h0};
        vecs[6] = '{6'h30, 1'b0, 1'b1, mk(1'b1, 5'd3, 32'h0BADF00D, 32'h1C00000C),
                    38'h0, 38'h0, 1'b0, 1'b0, 32'h0, 4'h0};
        vecs[7] = '{6'h00, 1'b0, 1'b1, mk(1'b1, 5'd3, 32'h0BADF00D, 32'h1C00000C),
                    mkrf(1'b1, 5'd3, 32'h0BADF00D), mkrf(1'b1, 5'd3, 32'h0BADF00D),
                    1'b0, 1'b0, 32'h0, 4'h0};

        resetn = 1'b0;
        stall = 6'h0;
        flush = 1'b0;
        ms_to_ws_bus = 102'h0;
        debug_wb_ready = 1'b0;
        #12;
        chk("reset_rf_bus", 64'(ws_to_rf_bus), 64'h0);
        chk("reset_ds_bus", 64'(ws_to_ds_bus), 64'h0);
        chk("reset_stallreq", 64'(stallreq_ws), 64'h0);
        chk("reset_dbg_valid", 64'(debug_wb_valid), 64'h0);
        chk("reset_dbg_pc", 64'(debug_wb_pc), 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            debug_wb_ready = vecs[i].ready;
            drive(vecs[i].stall, vecs[i].flush, vecs[i].bus);
            if (vecs[i].exp_rf[37]) chk($sformatf("v%0d_rf_bus", i), 64'(ws_to_rf_bus), 64'(vecs[i].exp_rf));
            else                    chk($sformatf("v%0d_rf_we", i), 64'(ws_to_rf_bus[37]), 64'h0);
            if (vecs[i].exp_ds != 38'h0) chk($sformatf("v%0d_ds_bus", i), 64'(ws_to_ds_bus), 64'(vecs[i].exp_ds));
            else                         chk($sformatf("v%0d_ds_we", i), 64'(ws_to_ds_bus[37]), 64'h0);
            chk($sformatf("v%0d_stallreq", i), 64'(stallreq_ws), 64'(vecs[i].exp_sreq));
            chk($sformatf("v%0d_dbg_valid", i), 64'(debug_wb_valid), 64'(vecs[i].exp_dv));
            chk($sformatf("v%0d_dbg_pc", i), 64'(debug_wb_pc), 64'(vecs[i].exp_dpc));
            chk($sformatf("v%0d_dbg_we", i), 64'(debug_wb_rf_we), 64'(vecs[i].exp_dwe));
        end

        // Back-pressure: consumer stalled, FIFO fills, fifth instruction waits.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(6'h00, 1'b0, mk(1'b1, 5'(k + 1), 32'h11 * (k + 1), 32'h100 + 32'(4 * k)));
        end
        chk("full_stallreq", 64'(stallreq_ws), 64'h1);
        chk("full_rf_we", 64'(ws_to_rf_bus[37]), 64'h0);
        chk("full_dbg_pc", 64'(debug_wb_pc), 64'h100);
        drive(6'h30, 1'b0, 102'h0);
        chk("full_hold_stallreq", 64'(stallreq_ws), 64'h1);
        debug_wb_ready = 1'b1;
        #1;
        chk("pop_stallreq", 64'(stallreq_ws), 64'h0);
        chk("pop_rf_bus", 64'(ws_to_rf_bus), 64'(mkrf(1'b1, 5'd5, 32'h55)));
        @(posedge clk);
        @(negedge clk);
        chk("pushpop_head_pc", 64'(debug_wb_pc), 64'h104);
        chk("pushpop_head_wnum", 64'(debug_wb_rf_wnum), 64'h2);
        debug_wb_ready = 1'b0;
        #1;
        chk("after_commit_stallreq", 64'(stallreq_ws), 64'h0);
        chk("after_commit_rf_we", 64'(ws_to_rf_bus[37]), 64'h0);
        chk("after_commit_ds", 64'(ws_to_ds_bus), 64'(mkrf(1'b1, 5'd5, 32'h55)));

        // Flush while WB cannot commit: instruction must be held until a pop.
        drive(6'h00, 1'b0, mk(1'b1, 5'd6, 32'h66, 32'h114));
        chk("flushA_pre_stallreq", 64'(stallreq_ws), 64'h1);
        drive(6'h00, 1'b1, mk(1'b1, 5'd7, 32'h77, 32'h118));
        chk("flushA_stallreq", 64'(stallreq_ws), 64'h1);
        chk("flushA_ds", 64'(ws_to_ds_bus), 64'(mkrf(1'b1, 5'd6, 32'h66)));
        flush = 1'b0;
        stall = 6'h30;
        debug_wb_ready = 1'b1;
        #1;
        chk("flushA_commit_rf", 64'(ws_to_rf_bus), 64'(mkrf(1'b1, 5'd6, 32'h66)));
        @(posedge clk);
        @(negedge clk);
        debug_wb_ready = 1'b0;
        drive(6'h00, 1'b1, mk(1'b1, 5'd7, 32'h77, 32'h118));
        chk("flushB_ds_we", 64'(ws_to_ds_bus[37]), 64'h0);
        chk("flushB_rf_we", 64'(ws_to_rf_bus[37]), 64'h0);
        chk("flushB_stallreq", 64'(stallreq_ws), 64'h0);

        // Hold for three cycles: one regfile write and one trace entry only.
        debug_wb_ready = 1'b1;
        writes = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive(6'h00, 1'b0, mk(1'b1, 5'd9, 32'h99, 32'h120));
            else if (c < 4) drive(6'h30, 1'b0, 102'h0);
            else drive(6'h10, 1'b0, 102'h0);
            if (ws_to_rf_bus[37]) writes++;
            if (debug_wb_valid && debug_wb_pc == 32'h120) seen++;
        end
        chk("hold_rf_writes", 64'(writes), 64'h1);
        chk("hold_trace_entries", 64'(seen), 64'h1);

        // Asynchronous reset with three trace entries and a commit in flight.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(6'h00, 1'b0, mk(1'b1, 5'(k + 10), 32'hA0 + 32'(k), 32'h200 + 32'(4 * k)));
        end
        chk("prereset_dbg_valid", 64'(debug_wb_valid), 64'h1);
        chk("prereset_rf_we", 64'(ws_to_rf_bus[37]), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_dbg_valid", 64'(debug_wb_valid), 64'h0);
        chk("areset_rf_bus", 64'(ws_to_rf_bus), 64'h0);
        chk("areset_dbg_pc", 64'(debug_wb_pc), 64'h0);
        @(negedge clk);
        resetn = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
